sd_dat_rx: RTL and testbench

SD card 4-bit data-line receiver that feeds the RX FIFO drained by the SD DMA engine. It samples DAT[3:0] on SD clock strobes, detects block start bits, and packs 512-byte data blocks into big-endian 32-bit words pushed to the RX FIFO. It also checks per-line CRC16 and end bits, and reports timeout, CRC and overflow status to the SD register block.

---
 rtl/sd_dat_rx.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sd_dat_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_rx.sv
`default_nettype none
// ============================================================================
// Module   : sd_dat_rx
// Purpose  : SD card 4-bit data-line receiver. Samples DAT[3:0] on SD clock
//            strobes, detects block start bits, packs 512-byte blocks into
//            big-endian 32-bit words for the RX FIFO, checks the per-line
//            CRC16 and end bits, and reports sticky timeout / CRC / overflow
//            status.
// Config   : define SD_DAT_RX_CRC_EN to build the four per-line CRC16
//            generators. Without it the CRC phase consumes its 16 strobes
//            unchecked and only the end-bit check can raise o_crc_error.
// Ports    :
//   i_clk            system clock
//   i_reset          synchronous active-high reset
//   i_sd_clk_strobe  one-cycle pulse at the SD clock sample point
//   i_sd_dat[3:0]    registered DAT pins, DAT3 is the nibble MSB
//   i_start          begin a multi-block receive (ignored while busy)
//   i_stop           abort, back to idle on the next cycle
//   i_block_count    blocks minus one, latched on an accepted i_start
//   o_busy           receive in progress
//   o_timeout        sticky: no start bit within P_TIMEOUT strobes
//   o_crc_error      sticky: CRC16 mismatch or bad end bit
//   o_overflow       sticky: word completed while the FIFO was full
//   o_rx_fifo_push   one-cycle push strobe
//   i_rx_fifo_full   FIFO full
//   o_rx_fifo_data   packed word, valid with o_rx_fifo_push
// Revision : 1.0 - initial release
// ============================================================================
module sd_dat_rx #(
  parameter logic [23:0] P_TIMEOUT = 24'd1_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe,
  input  logic [3:0]  i_sd_dat,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [7:0]  i_block_count,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_crc_error,
  output logic        o_overflow,
  output logic        o_rx_fifo_push,
  input  logic        i_rx_fifo_full,
  output logic [31:0] o_rx_fifo_data
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_CRC        = 3'd3;
  localparam logic [2:0] S_END        = 3'd4;

  // Last nibble index of a 512-byte block on a 4-bit bus.
  localparam logic [9:0] C_LAST_DATA_NIB = 10'd1023;
  // Last strobe index of the 16-bit CRC phase.
  localparam logic [3:0] C_LAST_CRC_NIB  = 4'd15;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]  state_q,     state_d;
  logic [7:0]  blk_cnt_q,   blk_cnt_d;
  logic [23:0] tmo_cnt_q,   tmo_cnt_d;
  // Shared nibble counter: data nibbles in DATA, CRC strobes in CRC.
  logic [9:0]  nib_cnt_q,   nib_cnt_d;
  // Holds the first seven nibbles of the word under assembly; the eighth
  // nibble is appended straight from the pins when the word is pushed.
  logic [27:0] shift_q,     shift_d;
  logic        timeout_q,   timeout_d;
  logic        crc_err_q,   crc_err_d;
  logic        ovf_q,       ovf_d;
  logic        push_q,      push_d;
  logic [31:0] data_q,      data_d;

  // Control towards the CRC generators.
  logic        crc_clr;
  logic        crc_upd;
  logic        crc_chk;
  logic [3:0]  crc_mis;

  logic [23:0] tmo_cnt_inc;
  logic        end_err;

  assign tmo_cnt_inc = tmo_cnt_q + 24'd1;
  // The END decision must see an end-bit error raised on this very strobe.
  assign end_err     = crc_err_q | (i_sd_dat != 4'hF);

  // --------------------------------------------------------------------------
  // Per-line CRC16 (x^16 + x^12 + x^5 + 1, init 0, MSB first)
  // --------------------------------------------------------------------------
`ifdef SD_DAT_RX_CRC_EN
  for (genvar l = 0; l < 4; l++) begin : g_crc_line
    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
      crc_d = crc_q;
      if (crc_clr) begin
        crc_d = 16'h0000;
      end else if (crc_upd) begin
        crc_d = {crc_q[14:0], 1'b0} ^
                ({16{crc_q[15] ^ i_sd_dat[l]}} & 16'h1021);
      end else if (crc_chk) begin
        // During the CRC phase the register is simply unloaded MSB first
        // and compared against the line.
        crc_d = {crc_q[14:0], 1'b0};
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        crc_q <= 16'h0000;
      end else begin
        crc_q <= crc_d;
      end
    end

    assign crc_mis[l] = crc_chk & (crc_q[15] != i_sd_dat[l]);
  end
`else
  logic unused_crc_ctrl;
  assign unused_crc_ctrl = crc_clr ^ crc_upd ^ crc_chk;
  assign crc_mis         = 4'b0000;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    nib_cnt_d = nib_cnt_q;
    shift_d   = shift_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    ovf_d     = ovf_q;
    push_d    = 1'b0;
    data_d    = data_q;
    crc_clr   = 1'b0;
    crc_upd   = 1'b0;
    crc_chk   = 1'b0;

    if (i_stop) begin
      // Abort wins over everything, including a coincident i_start.
      // Sticky flags are kept and no push is issued.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A strobe in the same cycle as i_start is deliberately ignored.
          if (i_start) begin
            blk_cnt_d = i_block_count;
            tmo_cnt_d = 24'd0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            ovf_d     = 1'b0;
            state_d   = S_WAIT_START;
          end
        end

        S_WAIT_START: begin
          if (i_sd_clk_strobe) begin
            if (i_sd_dat == 4'h0) begin
              nib_cnt_d = 10'd0;
              crc_clr   = 1'b1;
              state_d   = S_DATA;
            end else begin
              tmo_cnt_d = tmo_cnt_inc;
              if (tmo_cnt_inc == P_TIMEOUT) begin
                timeout_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
          end
        end

        S_DATA: begin
          if (i_sd_clk_strobe) begin
            shift_d   = {shift_q[23:0], i_sd_dat};
            crc_upd   = 1'b1;
            nib_cnt_d = nib_cnt_q + 10'd1;
            // Eighth nibble of a word: push it, or drop it on a full FIFO.
            if (nib_cnt_q[2:0] == 3'd7) begin
              if (i_rx_fifo_full) begin
                ovf_d = 1'b1;
              end else begin
                push_d = 1'b1;
                data_d = {shift_q, i_sd_dat};
              end
            end
            if (nib_cnt_q == C_LAST_DATA_NIB) begin
              nib_cnt_d = 10'd0;
              state_d   = S_CRC;
            end
          end
        end

        S_CRC: begin
          if (i_sd_clk_strobe) begin
            crc_chk   = 1'b1;
            nib_cnt_d = nib_cnt_q + 10'd1;
            if (crc_mis != 4'b0000) begin
              crc_err_d = 1'b1;
            end
            if (nib_cnt_q[3:0] == C_LAST_CRC_NIB) begin
              state_d = S_END;
            end
          end
        end

        S_END: begin
          if (i_sd_clk_strobe) begin
            crc_err_d = end_err;
            if (end_err || (blk_cnt_q == 8'd0)) begin
              state_d = S_IDLE;
            end else begin
              blk_cnt_d = blk_cnt_q - 8'd1;
              tmo_cnt_d = 24'd0;
              state_d   = S_WAIT_START;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      blk_cnt_q <= 8'd0;
      tmo_cnt_q <= 24'd0;
      nib_cnt_q <= 10'd0;
      shift_q   <= 28'd0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      push_q    <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      nib_cnt_q <= nib_cnt_d;
      shift_q   <= shift_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      ovf_q     <= ovf_d;
      push_q    <= push_d;
      data_q    <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_busy         = (state_q != S_IDLE);
  assign o_timeout      = timeout_q;
  assign o_crc_error    = crc_err_q;
  assign o_overflow     = ovf_q;
  assign o_rx_fifo_push = push_q;
  assign o_rx_fifo_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_dat_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_dat_rx
// Purpose  : Self-checking bench for sd_dat_rx. Random block payloads are
//            driven on randomly spaced strobes; expected words and line CRCs
//            come from a byte-array model (CRC by polynomial long division).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_dat_rx;

  localparam logic [23:0] TMO = 24'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [3:0]  sd_dat;
  logic        start;
  logic        stop;
  logic [7:0]  blk_count;
  logic        busy;
  logic        timeout;
  logic        crc_error;
  logic        overflow;
  logic        push;
  logic        full;
  logic [31:0] push_data;

  always #5 clk = ~clk;

  sd_dat_rx #(.P_TIMEOUT(TMO)) u_dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_sd_clk_strobe (strobe),
    .i_sd_dat        (sd_dat),
    .i_start         (start),
    .i_stop          (stop),
    .i_block_count   (blk_count),
    .o_busy          (busy),
    .o_timeout       (timeout),
    .o_crc_error     (crc_error),
    .o_overflow      (overflow),
    .o_rx_fifo_push  (push),
    .i_rx_fifo_full  (full),
    .o_rx_fifo_data  (push_data)
  );

`ifdef SD_DAT_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  blk [512];
  logic [15:0] blk_crc [4];

  // Capture every push cycle; a stretched push shows up as an extra word.
  always @(negedge clk) begin
    if (push) got_q.push_back(push_data);
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] nib_of(input int k);
    logic [7:0] b;
    b = blk[k/2];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
  endtask

  // CRC16 per line as the remainder of (message * x^16) mod g(x).
  task automatic model_crc();
    bit         m [1040];
    logic [3:0] nb;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 1040; k++) begin
        if (k < 1024) begin
          nb   = nib_of(k);
          m[k] = nb[l];
        end else begin
          m[k] = 1'b0;
        end
      end
      for (int i = 0; i < 1024; i++) begin
        if (m[i]) begin
          m[i]      = 1'b0;
          m[i + 4]  = ~m[i + 4];
          m[i + 11] = ~m[i + 11];
          m[i + 16] = ~m[i + 16];
        end
      end
      for (int j = 0; j < 16; j++) blk_crc[l][15 - j] = m[1024 + j];
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Gap of 1-2 idle clocks, then a one-cycle strobe; returns one step after
  // the sampling edge so registered results are already visible.
  task automatic send_nib(input logic [3:0] n);
    idle_cycles($urandom_range(1, 2));
    sd_dat = n;
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  // Start with a coincident start-bit strobe that must be ignored.
  task automatic do_start(input logic [7:0] cnt);
    idle_cycles(1);
    chk("busy_before_start", 32'(busy), 32'd0);
    start     = 1'b1;
    blk_count = cnt;
    strobe    = 1'b1;
    sd_dat    = 4'h0;
    @(posedge clk); #1;
    start  = 1'b0;
    strobe = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("flags_cleared", {29'd0, timeout, crc_error, overflow}, 32'd0);
  endtask

  task automatic send_block(input int full_word, input bit flip2, input logic [3:0] end_nib,
                            input int n_idle, input bit busy_after, input bit err_after_crc);
    logic [3:0] nb;
    model_crc();
    for (int w = 0; w < 128; w++)
      if (w != full_word) exp_q.push_back({blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]});
    for (int i = 0; i < n_idle; i++) send_nib(4'hF);
    send_nib(4'h0);
    for (int k = 0; k < 1024; k++) begin
      if (k % 8 == 0) full = (k / 8 == full_word);
      send_nib(nib_of(k));
    end
    full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 4; l++) nb[l] = blk_crc[l][15 - i];
      if (flip2 && i == 15) nb[2] = ~nb[2];
      send_nib(nb);
    end
    chk("crc_err_after_crc", 32'(crc_error), 32'(err_after_crc));
    chk("busy_before_end", 32'(busy), 32'd1);
    send_nib(end_nib);
    chk("busy_after_end", 32'(busy), 32'(busy_after));
  endtask

  task automatic check_words(input string tag, input int exp_n);
    idle_cycles(3);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; sd_dat = 4'hF; start = 1'b0; stop = 1'b0;
    blk_count = 8'd0; full = 1'b0;
    idle_cycles(4);
    rst = 1'b0;
    idle_cycles(1);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_timeout",  32'(timeout),   32'd0);
    chk("rst_crc",      32'(crc_error), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_push",     32'(push),      32'd0);
    chk("rst_data",     push_data,      32'd0);

    // Single block, counting byte pattern.
    for (int i = 0; i < 512; i++) blk[i] = 8'(i);
    do_start(8'd0);
    send_block(-1, 1'b0, 4'hF, 3, 1'b0, 1'b0);
    idle_cycles(3);
    chk("first_word", got_q[0], 32'h00010203);
    chk("last_word",  got_q[127], 32'hFCFDFEFF);
    chk("data_hold",  push_data, 32'hFCFDFEFF);
    chk("pattern_crc", 32'(crc_error), 32'd0);
    check_words("pattern", 128);

    // Three random blocks, 10 idle strobes before each.
    do_start(8'd2);
    for (int b = 0; b < 3; b++) begin
      fill_random();
      send_block(-1, 1'b0, 4'hF, 10, (b < 2), 1'b0);
    end
    chk("multi_flags", {29'd0, timeout, crc_error, overflow}, 32'd0);
    check_words("multi", 384);

    // DAT2 CRC bit 0 flipped on block 0 of 3.
    do_start(8'd2);
    fill_random();
    send_block(-1, 1'b1, 4'hF, 2, !CRC_ON, CRC_ON);
    if (CRC_ON) begin
      for (int i = 0; i < 4; i++) send_nib(4'hF);
      send_nib(4'h0);
      for (int i = 0; i < 40; i++) send_nib(4'($urandom));
      chk("flip_busy_low", 32'(busy), 32'd0);
      check_words("flip", 128);
    end else begin
      for (int b = 1; b < 3; b++) begin
        fill_random();
        send_block(-1, 1'b0, 4'hF, 4, (b < 2), 1'b0);
      end
      check_words("flip", 384);
    end

    // Timeout: DAT held high.
    do_start(8'd0);
    for (int i = 0; i < 99; i++) send_nib(4'hF);
    chk("tmo_not_yet", {30'd0, busy, timeout}, 32'd2);
    send_nib(4'hF);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_busy",    32'(busy),    32'd0);
    check_words("tmo", 0);

    // FIFO full during word 5 only.
    do_start(8'd0);
    fill_random();
    send_block(5, 1'b0, 4'hF, 2, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_crc",  32'(crc_error), 32'd0);
    check_words("ovf", 127);

    // Stop after three words (word 1 dropped to make overflow sticky).
    do_start(8'd0);
    fill_random();
    exp_q.push_back({blk[0], blk[1], blk[2], blk[3]});
    exp_q.push_back({blk[8], blk[9], blk[10], blk[11]});
    send_nib(4'hF);
    send_nib(4'h0);
    for (int k = 0; k < 24; k++) begin
      if (k % 8 == 0) full = (k / 8 == 1);
      send_nib(nib_of(k));
    end
    full = 1'b0;
    idle_cycles(1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_busy",    32'(busy),     32'd0);
    chk("stop_ovf_kept", 32'(overflow), 32'd1);
    for (int i = 0; i < 30; i++) send_nib(nib_of(24 + i));
    check_words("stop", 2);
    do_start(8'd0);
    fill_random();
    send_block(-1, 1'b0, 4'hF, 1, 1'b0, 1'b0);
    check_words("after_stop", 128);

    // Bad end nibble on block 0 of 2.
    do_start(8'd1);
    fill_random();
    send_block(-1, 1'b0, 4'hE, 3, 1'b0, 1'b0);
    chk("end_bit_err", 32'(crc_error), 32'd1);
    check_words("bad_end", 128);

    // Simultaneous start and stop while idle: stop wins, flags retained.
    start = 1'b1; stop = 1'b1; blk_count = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_crc",  32'(crc_error), 32'd1);
    idle_cycles(2);
    chk("startstop_busy_later", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
